// File: rtl/unary_add_pkg.sv
`default_nettype none
// ============================================================================
// Package : unary_add_pkg
// Brief   : Shared sizing helpers and FSM state encoding for unary_add_seq.
// Rev     : 1.0  initial release
// ============================================================================
package unary_add_pkg;

    localparam int OP_W_DEFAULT = 12;

    function automatic int res_w_of(input int op_w);
        return op_w + 1;
    endfunction

    function automatic int stream_len_of(input int op_w);
        return 2 ** op_w;
    endfunction

    localparam int RES_W_DEFAULT = res_w_of(OP_W_DEFAULT);
    localparam int STREAM_LEN    = stream_len_of(OP_W_DEFAULT);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_READ   = 3'd4,
        ST_RESP   = 3'd5
    } state_e;

endpackage
`default_nettype wire

// File: rtl/unary_add_seq_if.sv
`default_nettype none
// ============================================================================
// Interface : unary_add_seq_if
// Brief     : Request/response handshake bundle between requester and sequencer.
// Rev       : 1.0  initial release
// ============================================================================
interface unary_add_seq_if #(
    parameter int OP_W  = 12,
    parameter int RES_W = OP_W + 1
);
    logic             req_valid;
    logic             req_ready;
    logic [OP_W-1:0]  req_a;
    logic [OP_W-1:0]  req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [RES_W-1:0] rsp_sum;
    logic             rsp_c;
    logic             rsp_err;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_c, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_c, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/unary_stream_gen.sv
`default_nettype none
// ============================================================================
// Module : unary_stream_gen
// Brief  : Registered thermometer encoder: bit = en && (idx < operand).
// Rev    : 1.0  initial release
// ============================================================================
module unary_stream_gen #(
    parameter int OP_W = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [OP_W-1:0] operand,
    input  logic [OP_W-1:0] idx,
    output logic            stream
);
    logic stream_q;
    logic stream_d;

    always_comb begin
        stream_d = en && (idx < operand);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stream_q <= 1'b0;
        end else begin
            stream_q <= stream_d;
        end
    end

    assign stream = stream_q;
endmodule
`default_nettype wire

// File: rtl/unary_add_seq.sv
`default_nettype none
// ============================================================================
// Module : unary_add_seq
// Brief  : Job sequencer driving a unary adder with thermometer streams and
//          reading its count back serially. Build option UNARY_SEQ_CHECK_EN
//          adds an a+b reference compare that drives rsp_err.
// Rev    : 1.0  initial release
// ============================================================================
module unary_add_seq
    import unary_add_pkg::*;
#(
    parameter int OP_W  = OP_W_DEFAULT,
    parameter int RES_W = res_w_of(OP_W)
) (
    input  logic           clk,
    input  logic           rst_n,
    unary_add_seq_if.slave bus,
    output logic           busy,
    output logic           add_rst_n,
    output logic           add_en,
    output logic           add_a,
    output logic           add_b,
    output logic           add_rw,
    input  logic           add_dout,
    input  logic           add_c
);
    localparam int              WIN_LEN = stream_len_of(OP_W);
    localparam int              RD_W    = $clog2(RES_W);
    localparam logic [OP_W-1:0] IDX_END = OP_W'(WIN_LEN - 1);
    localparam logic [RD_W-1:0] RD_END  = RD_W'(RES_W - 1);

    state_e           state_q, state_d;
    logic [OP_W-1:0]  a_q, a_d, b_q, b_d, idx_q, idx_d;
    logic [RD_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [RES_W-1:0] sum_q, sum_d;
    logic             rsp_c_q, rsp_c_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             add_rst_n_q, add_rst_n_d;
    logic             add_en_q, add_en_d;
    logic             add_rw_q, add_rw_d;
    logic             accept;
    logic             stream_en;

    assign accept = (state_q == ST_IDLE) && req_ready_q && bus.req_valid;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        rd_cnt_d = rd_cnt_q;
        sum_d    = sum_q;
        rsp_c_d  = rsp_c_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d     = bus.req_a;
                    b_d     = bus.req_b;
                    idx_d   = '0;
                    sum_d   = '0;
                    rsp_c_d = 1'b0;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR:  state_d = ST_STREAM;
            ST_STREAM: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_END) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                rsp_c_d  = add_c;
                rd_cnt_d = '0;
                state_d  = ST_READ;
            end
            ST_READ: begin
                // LSB arrives first, so after RES_W shifts it sits at bit 0
                sum_d    = {add_dout, sum_q[RES_W-1:1]};
                rd_cnt_d = rd_cnt_q + 1'b1;
                if (rd_cnt_q == RD_END) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control pins are registered from the next state so they align with it
    always_comb begin
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        add_rst_n_d = (state_d != ST_CLEAR);
        add_en_d    = (state_d == ST_STREAM);
        add_rw_d    = (state_d == ST_READ) || (state_d == ST_RESP);
        stream_en   = (state_d == ST_STREAM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            idx_q       <= '0;
            rd_cnt_q    <= '0;
            sum_q       <= '0;
            rsp_c_q     <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            add_rst_n_q <= 1'b0;
            add_en_q    <= 1'b0;
            add_rw_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            idx_q       <= idx_d;
            rd_cnt_q    <= rd_cnt_d;
            sum_q       <= sum_d;
            rsp_c_q     <= rsp_c_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            add_rst_n_q <= add_rst_n_d;
            add_en_q    <= add_en_d;
            add_rw_q    <= add_rw_d;
        end
    end

    unary_stream_gen #(.OP_W(OP_W)) u_gen_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (stream_en),
        .operand (a_q),
        .idx     (idx_d),
        .stream  (add_a)
    );

    unary_stream_gen #(.OP_W(OP_W)) u_gen_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (stream_en),
        .operand (b_q),
        .idx     (idx_d),
        .stream  (add_b)
    );

`ifdef UNARY_SEQ_CHECK_EN
    logic [RES_W-1:0] ref_q, ref_d;

    always_comb begin
        ref_d = ref_q;
        if (accept) begin
            ref_d = RES_W'(bus.req_a) + RES_W'(bus.req_b);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_q <= '0;
        end else begin
            ref_q <= ref_d;
        end
    end

    assign bus.rsp_err = rsp_valid_q && (sum_q != ref_q);
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_c     = rsp_c_q;
    assign busy          = (state_q != ST_IDLE);
    assign add_rst_n     = add_rst_n_q;
    assign add_en        = add_en_q;
    assign add_rw        = add_rw_q;
endmodule
`default_nettype wire

// File: tb/tb_unary_add_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_unary_add_seq
// Brief  : Directed self-checking bench with a behavioural unary adder model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_unary_add_seq;
    localparam int OP_W  = 12;
    localparam int RES_W = 13;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    unary_add_seq_if #(.OP_W(OP_W), .RES_W(RES_W)) bus ();

    logic busy, add_rst_n, add_en, add_a, add_b, add_rw, add_dout, add_c;

    unary_add_seq #(.OP_W(OP_W), .RES_W(RES_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .add_rst_n (add_rst_n),
        .add_en    (add_en),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_rw    (add_rw),
        .add_dout  (add_dout),
        .add_c     (add_c)
    );

    // Behavioural adder: counts ones while enabled, shifts count out LSB first while reading
    logic [RES_W-1:0] m_cnt;
    int               m_rk;
    bit               flip_en;

    always @(posedge clk) begin
        if (!add_rst_n)   m_cnt <= '0;
        else if (add_rw)  m_cnt <= m_cnt >> 1;
        else if (add_en)  m_cnt <= m_cnt + RES_W'(add_a) + RES_W'(add_b);
        m_rk <= add_rw ? m_rk + 1 : 0;
    end

    assign add_c    = m_cnt[RES_W-1];
    assign add_dout = m_cnt[0] ^ (flip_en && add_rw && (m_rk == 0));

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic run_job(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                           input int hold, input bit flip,
                           input logic [RES_W-1:0] exp_sum, input bit exp_c,
                           input bit exp_err, input string nm);
        int n, mis, na, nb, wt, stab;
        bit seen, e_en, e_a, e_b;
        logic [RES_W-1:0] s0;
        flip_en       = flip;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b0;
        wt = 0;
        while (!bus.req_ready && wt < 20) begin
            @(negedge clk);
            wt++;
        end
        chk({nm, "_accept_ready"}, 32'(bus.req_ready), 32'd1);
        n = 0; mis = 0; na = 0; nb = 0; seen = 1'b0;
        while (!seen && n < 5000) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                bus.req_valid = 1'b0;
                bus.req_a     = '0;
                bus.req_b     = '0;
            end
            if (bus.rsp_valid) begin
                seen = 1'b1;
            end else begin
                e_en = (n >= 2) && (n <= 4097);
                e_a  = e_en && ((n - 2) < int'(a));
                e_b  = e_en && ((n - 2) < int'(b));
                if (add_en != e_en)              mis++;
                if (add_a != e_a)                mis++;
                if (add_b != e_b)                mis++;
                if (add_rst_n != (n != 1))       mis++;
                if (add_rw != (n >= 4099))       mis++;
                if (!busy || bus.req_ready)      mis++;
                na += int'(add_a);
                nb += int'(add_b);
            end
        end
        chk({nm, "_latency"}, 32'(n), 32'd4112);
        chk({nm, "_pin_mismatches"}, 32'(mis), 32'd0);
        chk({nm, "_a_ones"}, 32'(na), 32'(a));
        chk({nm, "_b_ones"}, 32'(nb), 32'(b));
        chk({nm, "_sum"}, 32'(bus.rsp_sum), 32'(exp_sum));
        chk({nm, "_c"}, 32'(bus.rsp_c), 32'(exp_c));
        chk({nm, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
        if (hold > 0) begin
            s0 = bus.rsp_sum;
            stab = 0;
            for (int i = 0; i < hold; i++) begin
                bus.req_valid = 1'b1;
                bus.req_a     = 12'h0AA;
                bus.req_b     = 12'h055;
                @(negedge clk);
                if (!bus.rsp_valid || bus.rsp_sum != s0 || bus.req_ready || !busy) stab++;
            end
            bus.req_valid = 1'b0;
            chk({nm, "_hold_unstable"}, 32'(stab), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk({nm, "_post_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({nm, "_post_ready"}, 32'(bus.req_ready), 32'd1);
        flip_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit flip_err;
`ifdef UNARY_SEQ_CHECK_EN
        flip_err = 1'b1;
`else
        flip_err = 1'b0;
`endif
        flip_en       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_add_rst_n", 32'(add_rst_n), 32'd0);
        chk("rst_add_pins", 32'({add_en, add_a, add_b, add_rw}), 32'd0);
        chk("rst_sum", 32'(bus.rsp_sum), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_req_ready_before_clk", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        chk("rel_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rel_add_rst_n", 32'(add_rst_n), 32'd1);

        run_job(12'd3,    12'd5,    0,  1'b0, 13'd8,    1'b0, 1'b0, "a3b5");
        run_job(12'd0,    12'd0,    0,  1'b0, 13'd0,    1'b0, 1'b0, "zero");
        run_job(12'd4095, 12'd4095, 0,  1'b0, 13'd8190, 1'b1, 1'b0, "max");
        run_job(12'd100,  12'd200,  20, 1'b0, 13'd300,  1'b0, 1'b0, "hold");

        // Abort a job mid-stream with an asynchronous reset pulse
        bus.req_a     = 12'd7;
        bus.req_b     = 12'd9;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (100) @(negedge clk);
        chk("abort_in_stream", 32'(add_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_pins", 32'({add_rst_n, add_en, add_a, add_b, add_rw}), 32'd0);
        chk("abort_handshake", 32'({bus.req_ready, bus.rsp_valid}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready_again", 32'(bus.req_ready), 32'd1);

        run_job(12'd1,    12'd2,    0,  1'b0, 13'd3,    1'b0, 1'b0, "after_rst");
        run_job(12'd10,   12'd6,    0,  1'b1, 13'd17,   1'b0, flip_err, "flip");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
